// File: rtl/dmem_wait_ctrl.sv
// Data-memory stage with an IDLE/BUSY/DONE wait-state handshake that stalls the PC.
// Optional alignment/range fault reporting on Error is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_wait_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        Stall,
    output logic        Busy,
    output logic        Error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t             state;
    state_t             next_state;
    logic [3:0]         count;
    logic [63:0]        addr_q;
    logic [63:0]        wdata_q;
    logic               write_q;
    logic               req;

    logic [63:0]        eff_addr;
    logic [63:0]        eff_wdata;
    logic               eff_write;
    logic [ADDR_W-1:0]  eff_idx;
    logic               eff_fault;
    logic               enter_done;

    logic [ADDR_W-1:0]  q_idx;
    logic               q_fault;

    logic [63:0]        mem [DEPTH];

    // A simultaneous read and write is a write; the read strobe only matters for req.
    assign req = MemoryRead | MemoryWrite;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        Busy       = 1'b0;
        case (state)
            IDLE: begin
                Stall = req;
                if (req) begin
                    next_state = (LATENCY == 0) ? DONE : BUSY;
                end
            end
            LATCH: begin
                Busy       = 1'b1;
                next_state = IDLE;
            end
            BUSY: begin
                Stall = 1'b1;
                Busy  = 1'b1;
                if (count == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state   <= IDLE;
            count   <= 4'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            write_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                addr_q  <= Address;
                wdata_q <= WriteData;
                write_q <= MemoryWrite;
                count   <= CNT_LOAD;
            end else if (state == BUSY && count != 4'd0) begin
                count <= count - 4'd1;
            end
        end
    end

    // The access entering DONE comes straight from the ports when LATENCY is 0.
    assign eff_addr   = (state == IDLE) ? Address     : addr_q;
    assign eff_wdata  = (state == IDLE) ? WriteData   : wdata_q;
    assign eff_write  = (state == IDLE) ? MemoryWrite : write_q;
    assign eff_idx    = eff_addr[ADDR_W+2:3];
    assign enter_done = (next_state == DONE);
    assign q_idx      = addr_q[ADDR_W+2:3];

`ifdef DMEM_ALIGN_CHECK_EN
    assign eff_fault = (|eff_addr[63:ADDR_W+3]) | (|eff_addr[2:0]);
    assign q_fault   = (|addr_q[63:ADDR_W+3])   | (|addr_q[2:0]);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            Error <= 1'b0;
        end else begin
            Error <= enter_done & eff_fault;
        end
    end
`else
    logic unused_addr_lsb;

    assign eff_fault       = |eff_addr[63:ADDR_W+3];
    assign q_fault         = |addr_q[63:ADDR_W+3];
    assign Error           = 1'b0;
    assign unused_addr_lsb = ^{eff_addr[2:0], addr_q[2:0]};
`endif

    // NOTE: the array has no reset so it maps onto RAM and keeps its contents across Reset_L.
    always_ff @(posedge CLK) begin
        if (enter_done && eff_write && !eff_fault) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ReadData <= 64'd0;
        end else if (state == DONE && !write_q) begin
            ReadData <= q_fault ? 64'd0 : mem[q_idx];
        end
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: one LATENCY=2 and one LATENCY=0 instance, scoreboarded reads.
// Error expectations follow DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_wait_ctrl;

    localparam int ADDR_W = 8;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [63:0] a_rdata, b_rdata;
    logic        a_stall, a_busy, a_err, b_stall, b_busy, b_err;

    always #5 CLK = ~CLK;

    dmem_wait_ctrl #(.ADDR_W(ADDR_W), .LATENCY(2)) u_a (
        .CLK(CLK), .Reset_L(Reset_L), .MemoryRead(a_rd), .MemoryWrite(a_wr),
        .Address(a_addr), .WriteData(a_wdata), .ReadData(a_rdata),
        .Stall(a_stall), .Busy(a_busy), .Error(a_err)
    );

    dmem_wait_ctrl #(.ADDR_W(ADDR_W), .LATENCY(0)) u_b (
        .CLK(CLK), .Reset_L(Reset_L), .MemoryRead(b_rd), .MemoryWrite(b_wr),
        .Address(b_addr), .WriteData(b_wdata), .ReadData(b_rdata),
        .Stall(b_stall), .Busy(b_busy), .Error(b_err)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] mdl_a [longint];
    logic [63:0] mdl_b [longint];
    logic [63:0] last_rd [2];
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [63:0] addr);
        return |addr[63:ADDR_W+3];
    endfunction

    function automatic bit faulty(input logic [63:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        return out_of_range(addr) || (addr[2:0] != 3'd0);
`else
        return out_of_range(addr);
`endif
    endfunction

    function automatic logic exp_error(input logic [63:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        return faulty(addr);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] data);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = data;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
        end
    endtask

    task automatic get(input bit sel, output logic [63:0] rdata, output logic stall,
                       output logic busy, output logic err);
        rdata = sel ? b_rdata : a_rdata;
        stall = sel ? b_stall : a_stall;
        busy  = sel ? b_busy  : a_busy;
        err   = sel ? b_err   : a_err;
    endtask

    // One complete access; inputs are scrambled after capture to prove they are ignored.
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [63:0] addr, input logic [63:0] data, input string tag);
        int          lat = sel ? 0 : 2;
        longint      idx = longint'(addr[ADDR_W+2:3]);
        bit          drop = faulty(addr);
        logic [63:0] rdata;
        logic        stall, busy, err;

        @(negedge CLK);
        drive(sel, rd, wr, addr, data);
        if (wr) begin
            if (!drop) begin
                if (sel) mdl_b[idx] = data;
                else     mdl_a[idx] = data;
            end
        end else begin
            exp_q.push_back(drop ? 64'd0 : (sel ? mdl_b[idx] : mdl_a[idx]));
        end
        #1 get(sel, rdata, stall, busy, err);
        check({tag, " idle stall"}, 64'(stall), 64'd1);
        check({tag, " idle busy"}, 64'(busy), 64'd0);

        for (int i = 0; i < lat; i++) begin
            @(negedge CLK);
            drive(sel, 1'b0, 1'b0, ~addr, ~data);
            #1 get(sel, rdata, stall, busy, err);
            check({tag, " busy stall"}, 64'(stall), 64'd1);
            check({tag, " busy busy"}, 64'(busy), 64'd1);
        end

        @(negedge CLK);
        if (lat == 0) drive(sel, 1'b0, 1'b0, ~addr, ~data);
        #1 get(sel, rdata, stall, busy, err);
        check({tag, " done stall"}, 64'(stall), 64'd0);
        check({tag, " done busy"}, 64'(busy), 64'd0);
        check({tag, " done error"}, 64'(err), 64'(exp_error(addr)));

        @(negedge CLK);
        #1 get(sel, rdata, stall, busy, err);
        check({tag, " after error"}, 64'(err), 64'd0);
        check({tag, " after stall"}, 64'(stall), 64'd0);
        if (wr) begin
            check({tag, " rdata held"}, rdata, last_rd[sel]);
        end else begin
            last_rd[sel] = exp_q.pop_front();
            check({tag, " rdata"}, rdata, last_rd[sel]);
        end
    endtask

    initial begin
        Reset_L    = 1'b0;
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

        @(negedge CLK);
        @(negedge CLK);
        check("reset a rdata", a_rdata, 64'd0);
        check("reset a stall", 64'(a_stall), 64'd0);
        check("reset a busy", 64'(a_busy), 64'd0);
        check("reset a error", 64'(a_err), 64'd0);
        check("reset b rdata", b_rdata, 64'd0);
        Reset_L = 1'b1;

        access(1'b0, 1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, "a wr 0x10");
        access(1'b0, 1'b1, 1'b0, 64'h10, 64'd0, "a rd 0x10");

        access(1'b1, 1'b0, 1'b1, 64'h0, 64'h5, "b wr 0x0");
        access(1'b1, 1'b1, 1'b0, 64'h0, 64'd0, "b rd 0x0");
        access(1'b1, 1'b0, 1'b1, 64'h800, 64'h55, "b wr oor");
        access(1'b1, 1'b1, 1'b0, 64'h0, 64'd0, "b rd 0x0 after oor");
        access(1'b1, 1'b1, 1'b0, 64'h800, 64'd0, "b rd oor");

        access(1'b0, 1'b1, 1'b1, 64'h18, 64'h7, "a rdwr 0x18");
        access(1'b0, 1'b1, 1'b0, 64'h18, 64'd0, "a rd 0x18");

        access(1'b0, 1'b0, 1'b1, 64'h20, 64'h1111, "a wr 0x20");
        access(1'b0, 1'b1, 1'b0, 64'h20, 64'd0, "a rd 0x20");

        // Interrupted write of 9: model is left untouched since the write never lands.
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b1, 64'h20, 64'h9);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        #1 check("pre-reset busy", 64'(a_busy), 64'd1);
        Reset_L = 1'b0;
        #1;
        check("mid reset stall", 64'(a_stall), 64'd0);
        check("mid reset busy", 64'(a_busy), 64'd0);
        check("mid reset a rdata", a_rdata, 64'd0);
        check("mid reset b rdata", b_rdata, 64'd0);
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        @(negedge CLK);
        Reset_L = 1'b1;
        access(1'b0, 1'b1, 1'b0, 64'h20, 64'd0, "a rd 0x20 after reset");

        access(1'b0, 1'b1, 1'b0, 64'h1_0000_0000, 64'd0, "a rd oor");

        access(1'b0, 1'b0, 1'b1, 64'h13, 64'hABCD, "a wr 0x13");
        access(1'b0, 1'b1, 1'b0, 64'h10, 64'd0, "a rd 0x10 after misaligned");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
